// File: rtl/riscv_mem_stage.sv
// riscv_mem_stage: MEM pipeline stage driving a req/gnt/rvalid data bus with a registered writeback result.
//   in : clk, rst (async, active high), rd_idx_i/rd_we_i/data_we_i/data_re_i/data_addr_i from EX/MEM,
//        store_data_i, mem_size_i (00 byte, 01 half, 1x word), mem_unsigned_i, alu_result_i,
//        dbus_gnt_i, dbus_rvalid_i, dbus_rdata_i
//   out: dbus_req_o/we_o/addr_o/be_o/wdata_o, stall_o, misalign_o, bus_err_o, rd_idx_o/rd_we_o/rd_wdata_o
module riscv_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_idx_i,
  input  logic        rd_we_i,
  input  logic        data_we_i,
  input  logic        data_re_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] alu_result_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [4:0]  rd_idx_o,
  output logic        rd_we_o,
  output logic [31:0] rd_wdata_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic TO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d, rd_we_q, rd_we_d, mis_q, mis_d, err_q, err_d, luns_q, luns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_wdata_q, rd_wdata_d;
  logic [3:0] be_q, be_d;
  logic [4:0] lidx_q, lidx_d, rd_idx_q, rd_idx_d;
  logic [1:0] lsize_q, lsize_d, loff_q, loff_d;
  logic access, misal, launch, done_st, done_ld, timeout;
  logic [31:0] sh, ld;
  assign access  = data_re_i | data_we_i;
  assign misal   = (mem_size_i == 2'b01 && data_addr_i[0]) || (mem_size_i[1] && |data_addr_i[1:0]);
  assign launch  = state_q == IDLE && access && !misal;
  assign done_st = state_q == REQ && dbus_gnt_i && we_q;
  assign done_ld = state_q == WAIT && dbus_rvalid_i;
  // completion on the limit cycle wins over the abort
  assign timeout = TO_EN && state_q != IDLE && !done_st && !done_ld && cnt_q == LIM;
  // a load's gnt is not completion: stay stalled until rvalid so the held instruction is not skipped
  assign stall_o = launch || (state_q == REQ && !done_st && !timeout) || (state_q == WAIT && !done_ld && !timeout);
  assign sh = dbus_rdata_i >> {loff_q, 3'b000};
  assign ld = lsize_q == 2'b00 ? {{24{!luns_q && sh[7]}}, sh[7:0]} :
              lsize_q == 2'b01 ? {{16{!luns_q && sh[15]}}, sh[15:0]} : dbus_rdata_i;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    lidx_d = lidx_q;
    lsize_d = lsize_q;
    luns_d = luns_q;
    loff_d = loff_q;
    rd_idx_d = rd_idx_q;
    rd_wdata_d = rd_wdata_q;
    rd_we_d = 1'b0;
    mis_d = 1'b0;
    err_d = 1'b0;
    if (launch) begin
      state_d = REQ;
      cnt_d = '0;
      req_d = 1'b1;
      we_d = data_we_i;
      addr_d = {data_addr_i[31:2], 2'b00};
      be_d = mem_size_i == 2'b00 ? 4'b0001 << data_addr_i[1:0] :
             mem_size_i == 2'b01 ? 4'b0011 << {data_addr_i[1], 1'b0} : 4'b1111;
      wdata_d = mem_size_i == 2'b00 ? {4{store_data_i[7:0]}} :
                mem_size_i == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
      lidx_d = rd_idx_i;
      lsize_d = mem_size_i;
      luns_d = mem_unsigned_i;
      loff_d = data_addr_i[1:0];
    end else if (state_q == IDLE && access) begin
      mis_d = 1'b1;
    end else if (state_q == IDLE) begin
      rd_idx_d = rd_idx_i;
      rd_wdata_d = alu_result_i;
      rd_we_d = rd_we_i && rd_idx_i != 5'd0;
    end else if (done_ld) begin
      state_d = IDLE;
      rd_idx_d = lidx_q;
      rd_wdata_d = ld;
      rd_we_d = lidx_q != 5'd0;
    end else if (done_st || timeout) begin
      state_d = IDLE;
      req_d = 1'b0;
      err_d = timeout;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (state_q == REQ && dbus_gnt_i) begin
        state_d = WAIT;
        req_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      lidx_q <= '0;
      lsize_q <= '0;
      luns_q <= 1'b0;
      loff_q <= '0;
      rd_idx_q <= '0;
      rd_wdata_q <= '0;
      rd_we_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      lidx_q <= lidx_d;
      lsize_q <= lsize_d;
      luns_q <= luns_d;
      loff_q <= loff_d;
      rd_idx_q <= rd_idx_d;
      rd_wdata_q <= rd_wdata_d;
      rd_we_q <= rd_we_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end
  assign dbus_req_o = req_q;
  assign dbus_we_o = we_q;
  assign dbus_addr_o = addr_q;
  assign dbus_be_o = be_q;
  assign dbus_wdata_o = wdata_q;
  assign misalign_o = mis_q;
  assign bus_err_o = err_q;
  assign rd_idx_o = rd_idx_q;
  assign rd_we_o = rd_we_q;
  assign rd_wdata_o = rd_wdata_q;
endmodule

// File: tb/tb_riscv_mem_stage.sv
// tb_riscv_mem_stage: directed self-checking bench for riscv_mem_stage.
module tb_riscv_mem_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rd_idx_i, rd_idx_o;
  logic rd_we_i, data_we_i, data_re_i, mem_unsigned_i, dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] data_addr_i, store_data_i, alu_result_i, dbus_rdata_i;
  logic [1:0] mem_size_i;
  logic dbus_req_o, dbus_we_o, stall_o, misalign_o, bus_err_o, rd_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, rd_wdata_o;
  logic [3:0] dbus_be_o;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  riscv_mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .rd_idx_i(rd_idx_i), .rd_we_i(rd_we_i), .data_we_i(data_we_i),
    .data_re_i(data_re_i), .data_addr_i(data_addr_i), .store_data_i(store_data_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .alu_result_i(alu_result_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .rd_idx_o(rd_idx_o), .rd_we_o(rd_we_o),
    .rd_wdata_o(rd_wdata_o)
  );
  typedef struct {
    logic re, we;
    logic [31:0] addr;
    logic [1:0] size;
    logic [4:0] idx;
    logic rwe;
    logic [31:0] alu;
    logic ewe;
    logic [4:0] eidx;
    logic [31:0] ewd;
    logic emis;
    logic chkd;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic nop();
    data_re_i = 0; data_we_i = 0; rd_we_i = 0; rd_idx_i = 0; alu_result_i = 0;
    data_addr_i = 0; mem_size_i = 0; mem_unsigned_i = 0; store_data_i = 0;
  endtask
  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [4:0] idx,
                      input logic [31:0] rdata, input int waitc, input logic [3:0] ebe, input logic [31:0] eval);
    @(posedge clk); #1 nop();
    data_re_i = 1; data_addr_i = a; mem_size_i = sz; mem_unsigned_i = u; rd_idx_i = idx; rd_we_i = 1;
    @(negedge clk); chk("ld_launch_stall", stall_o, 1);
    @(posedge clk); #1 dbus_gnt_i = 1;
    @(negedge clk);
    chk("ld_req", dbus_req_o, 1); chk("ld_we", dbus_we_o, 0);
    chk("ld_addr", dbus_addr_o, {a[31:2], 2'b00}); chk("ld_be", dbus_be_o, ebe);
    chk("ld_gnt_stall", stall_o, 1);
    @(posedge clk); #1 dbus_gnt_i = 0;
    for (int k = 1; k < waitc; k++) begin
      @(negedge clk);
      chk("ld_wait_stall", stall_o, 1); chk("ld_wait_req", dbus_req_o, 0); chk("ld_wait_rdwe", rd_we_o, 0);
      @(posedge clk); #1;
    end
    dbus_rvalid_i = 1; dbus_rdata_i = rdata;
    @(negedge clk); chk("ld_done_stall", stall_o, 0);
    @(posedge clk); #1 dbus_rvalid_i = 0; nop();
    @(negedge clk);
    chk("ld_rdwe", rd_we_o, 1); chk("ld_rdidx", rd_idx_o, idx); chk("ld_data", rd_wdata_o, eval);
    chk("ld_idle_stall", stall_o, 0);
  endtask
  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n, seen;
    logic last;
    v[0] = '{1'b0, 1'b0, 32'h0,    2'd0, 5'd5, 1'b1, 32'h1234, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b1};
    v[1] = '{1'b0, 1'b0, 32'h0,    2'd0, 5'd0, 1'b1, 32'h5555, 1'b0, 5'd0, 32'h5555, 1'b0, 1'b1};
    v[2] = '{1'b0, 1'b0, 32'h0,    2'd0, 5'd7, 1'b0, 32'hDEAD, 1'b0, 5'd7, 32'hDEAD, 1'b0, 1'b1};
    v[3] = '{1'b1, 1'b0, 32'h3002, 2'd2, 5'd8, 1'b1, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0};
    v[4] = '{1'b0, 1'b1, 32'h41,   2'd1, 5'd0, 1'b0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0};
    v[5] = '{1'b1, 1'b0, 32'h1,    2'd3, 5'd9, 1'b1, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 1'b0};
    nop(); dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", dbus_req_o, 0); chk("rst_stall", stall_o, 0); chk("rst_rdwe", rd_we_o, 0);
    chk("rst_wdata", rd_wdata_o, 0); chk("rst_addr", dbus_addr_o, 0); chk("rst_be", dbus_be_o, 0);
    chk("rst_mis", misalign_o, 0); chk("rst_err", bus_err_o, 0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1
      data_re_i = v[i].re; data_we_i = v[i].we; data_addr_i = v[i].addr; mem_size_i = v[i].size;
      rd_idx_i = v[i].idx; rd_we_i = v[i].rwe; alu_result_i = v[i].alu;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall_o, 0);
      chk($sformatf("vec%0d_mis_prev", i), misalign_o, 0);
      @(posedge clk); #1 nop();
      @(negedge clk);
      chk($sformatf("vec%0d_rdwe", i), rd_we_o, v[i].ewe);
      chk($sformatf("vec%0d_mis", i), misalign_o, v[i].emis);
      chk($sformatf("vec%0d_req", i), dbus_req_o, 0);
      if (v[i].chkd) begin
        chk($sformatf("vec%0d_idx", i), rd_idx_o, v[i].eidx);
        chk($sformatf("vec%0d_wdata", i), rd_wdata_o, v[i].ewd);
      end
    end
    // store byte at 0x1003, gnt on the third bus cycle
    @(posedge clk); #1 nop();
    data_we_i = 1; data_addr_i = 32'h1003; mem_size_i = 0; store_data_i = 32'h123456AB; rd_idx_i = 3;
    @(negedge clk); chk("st_stall1", stall_o, 1);
    @(posedge clk);
    @(negedge clk);
    chk("st_req", dbus_req_o, 1); chk("st_we", dbus_we_o, 1); chk("st_addr", dbus_addr_o, 32'h1000);
    chk("st_be", dbus_be_o, 4'b1000); chk("st_wdata", dbus_wdata_o, 32'hABABABAB); chk("st_stall2", stall_o, 1);
    @(posedge clk);
    @(negedge clk); chk("st_stall3", stall_o, 1); chk("st_rdwe_stall", rd_we_o, 0);
    @(posedge clk); #1 dbus_gnt_i = 1;
    @(negedge clk); chk("st_gnt_stall", stall_o, 0); chk("st_gnt_req", dbus_req_o, 1);
    @(posedge clk); #1 dbus_gnt_i = 0; nop();
    @(negedge clk); chk("st_done_req", dbus_req_o, 0); chk("st_rdwe", rd_we_o, 0); chk("st_idle_stall", stall_o, 0);
    load(32'h2001, 2'd0, 1'b0, 5'd10, 32'h0000_8000, 3, 4'b0010, 32'hFFFFFF80);
    load(32'h2001, 2'd0, 1'b1, 5'd11, 32'h0000_8000, 2, 4'b0010, 32'h00000080);
    load(32'h2002, 2'd1, 1'b0, 5'd12, 32'h8001_0000, 1, 4'b1100, 32'hFFFF8001);
    load(32'h2006, 2'd1, 1'b1, 5'd13, 32'h8001_0000, 1, 4'b1100, 32'h00008001);
    load(32'h2004, 2'd2, 1'b0, 5'd9,  32'hCAFEBABE, 1, 4'b1111, 32'hCAFEBABE);
    // timeout: gnt never arrives
    @(posedge clk); #1 nop();
    data_re_i = 1; data_addr_i = 32'h5000; mem_size_i = 2; rd_idx_i = 4; rd_we_i = 1;
    n = 0; seen = 0; last = 1'b1;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus_err_o) seen = 1;
      else if (dbus_req_o) begin
        n++;
        last = stall_o;
        if (!stall_o) nop();
      end
    end
    chk("to_req_cycles", n, 4); chk("to_err_seen", seen, 1); chk("to_abort_stall", last, 0);
    chk("to_req_low", dbus_req_o, 0); chk("to_stall_low", stall_o, 0); chk("to_rdwe", rd_we_o, 0);
    @(negedge clk); chk("to_err_pulse", bus_err_o, 0); chk("to_idle_stall", stall_o, 0);
    // reset while waiting for rvalid
    @(posedge clk); #1 nop();
    data_re_i = 1; data_addr_i = 32'h6000; mem_size_i = 2; rd_idx_i = 3; rd_we_i = 1;
    @(posedge clk); #1 dbus_gnt_i = 1;
    @(posedge clk); #1 dbus_gnt_i = 0;
    @(negedge clk); chk("rw_wait_stall", stall_o, 1);
    #1 nop(); rst = 1;
    #1;
    chk("rw_req", dbus_req_o, 0); chk("rw_stall", stall_o, 0); chk("rw_rdwe", rd_we_o, 0);
    chk("rw_wdata", rd_wdata_o, 0); chk("rw_idx", rd_idx_o, 0); chk("rw_addr", dbus_addr_o, 0);
    @(posedge clk); #1 rst = 0; dbus_rvalid_i = 1; dbus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk); chk("rw_late_stall", stall_o, 0);
    @(posedge clk); #1 dbus_rvalid_i = 0;
    @(negedge clk); chk("rw_late_rdwe", rd_we_o, 0); chk("rw_late_wdata", rd_wdata_o, 0); chk("rw_late_req", dbus_req_o, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
